// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path.
//   - Coordinate / address widths and default display resolution.
//   - Issue FSM state encoding.
//   - Layout of one pending write entry {addr, wdata, be}.
package fb_pkg;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int ADDR_W    = 23;
  localparam int IDX_W     = 19;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } fbw_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [1:0]        be;
  } fbw_entry_t;

  localparam int ENTRY_W = $bits(fbw_entry_t);

endpackage

// File: rtl/fbw_fifo.sv
// Small synchronous FIFO of pending framebuffer writes.
// Ports:
//   clk, reset        clock, asynchronous active-low reset (pointers/count only)
//   push, push_data   enqueue an entry (ignored when full, even if popping)
//   pop               dequeue the head entry (ignored when empty)
//   head_data         current head entry
//   tail_data         most recently pushed entry
//   tail_wr, tail_wr_data  overwrite the tail entry in place (write merging)
//   count, full, empty     occupancy, all derived from the registered count
module fbw_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_data,
  output logic [ENTRY_W-1:0] tail_data,
  input  logic               tail_wr,
  input  logic [ENTRY_W-1:0] tail_wr_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign tail_ptr = wr_ptr - 1'b1;

  assign head_data = mem[rd_ptr];
  assign tail_data = mem[tail_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push)           mem[wr_ptr]   <= push_data;
    if (tail_wr && !empty) mem[tail_ptr] <= tail_wr_data;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel write front-end for the 16-bit-word framebuffer.
// Accepts (x, y, rgb) pixel writes, maps them to a word address and byte
// lane, queues them and issues single-word byte-masked writes to the
// memory controller (same request handshake as the display read side).
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   px_valid/px_ready, px_x/px_y/px_rgb   pixel write port
//   req_access, rd, burst, addr, wdata, be   controller request (rd=0, burst=0)
//   op_begun, op_finished, ctrlr_good        controller status
// Build option:
//   FBW_MERGE_EN  when defined, a pixel landing in the same word as the queue
//                 tail (not yet being issued) is folded into that entry.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int                H_RES      = DEF_H_RES,
  parameter int                V_RES      = DEF_V_RES,
  parameter logic [ADDR_W-1:0] FB_BASE    = 23'h000000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [X_W-1:0]    px_x,
  input  logic [Y_W-1:0]    px_y,
  input  logic [7:0]        px_rgb,
  output logic              req_access,
  output logic              rd,
  output logic              burst,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       wdata,
  output logic [1:0]        be,
  input  logic              op_begun,
  input  logic              op_finished,
  input  logic              ctrlr_good
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef FBW_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  function automatic logic [IDX_W-1:0] pix_index(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return IDX_W'(y) * IDX_W'(H_RES) + IDX_W'(x);
  endfunction

  function automatic fbw_entry_t make_entry(input logic [IDX_W-1:0] idx,
                                            input logic [7:0]       rgb);
    fbw_entry_t e;
    e.addr  = FB_BASE + ADDR_W'(idx[IDX_W-1:1]);
    e.wdata = {rgb, rgb};
    e.be    = idx[0] ? 2'b10 : 2'b01;
    return e;
  endfunction

  // Newer pixel wins its lane; the other lane of the old entry is kept.
  function automatic fbw_entry_t merge_entry(input fbw_entry_t old_e,
                                             input fbw_entry_t new_e);
    fbw_entry_t e;
    e    = old_e;
    e.be = old_e.be | new_e.be;
    if (new_e.be[1]) e.wdata[15:8] = new_e.wdata[15:8];
    else             e.wdata[7:0]  = new_e.wdata[7:0];
    return e;
  endfunction

  fbw_state_t         state;
  logic [IDX_W-1:0]   px_idx;
  logic               px_in_range;
  logic               accept;
  fbw_entry_t         px_entry;
  fbw_entry_t         head_entry;
  fbw_entry_t         tail_entry;
  fbw_entry_t         merged_entry;
  fbw_entry_t         issue_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic [ENTRY_W-1:0] tail_bits;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               tail_is_head;
  logic               merge_hit;

  assign rd    = 1'b0;
  assign burst = 1'b0;

  assign px_ready    = !fifo_full;
  assign accept      = px_valid && px_ready;
  assign px_idx      = pix_index(px_x, px_y);
  assign px_in_range = (int'(px_x) < H_RES) && (int'(px_y) < V_RES);
  assign px_entry    = make_entry(px_idx, px_rgb);

  assign head_entry   = head_bits;
  assign tail_entry   = tail_bits;
  assign tail_is_head = (fifo_count == CNT_W'(1));

  // The tail may only be modified when it is not the entry currently held
  // on the controller outputs (REQ/BUSY with a single queued entry).
  assign merge_hit = MERGE_EN && accept && px_in_range && !fifo_empty &&
                     (tail_entry.addr == px_entry.addr) &&
                     (!tail_is_head || state == ST_IDLE);

  assign merged_entry = merge_entry(tail_entry, px_entry);
  assign fifo_push    = accept && px_in_range && !merge_hit;
  assign fifo_pop     = (state == ST_BUSY) && op_finished;

  // A merge into the head on the same edge the head is issued must reach
  // the outputs too, otherwise the merged lane would be lost at pop.
  assign issue_entry = (merge_hit && tail_is_head) ? merged_entry : head_entry;

  fbw_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .push_data    (px_entry),
    .pop          (fifo_pop),
    .head_data    (head_bits),
    .tail_data    (tail_bits),
    .tail_wr      (merge_hit),
    .tail_wr_data (merged_entry),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_access <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      be         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && ctrlr_good) begin
            addr       <= issue_entry.addr;
            wdata      <= issue_entry.wdata;
            be         <= issue_entry.be;
            req_access <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Once the controller has latched the request it will perform
          // the write, so op_begun wins over a simultaneous ctrlr_good drop.
          if (op_begun) begin
            req_access <= 1'b0;
            state      <= ST_BUSY;
          end else if (!ctrlr_good) begin
            req_access <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (op_finished) state <= ST_IDLE;
        end
        default: begin
          req_access <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer (FB_BASE = 0, 640x480, depth 4).
module tb_framebuffer_writer;

  logic        clk;
  logic        reset;
  logic        px_valid;
  logic        px_ready;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [7:0]  px_rgb;
  logic        req_access;
  logic        rd;
  logic        burst;
  logic [22:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        op_begun;
  logic        op_finished;
  logic        ctrlr_good;

  int n_chk  = 0;
  int n_fail = 0;

  framebuffer_writer dut (
    .clk         (clk),
    .reset       (reset),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_rgb      (px_rgb),
    .req_access  (req_access),
    .rd          (rd),
    .burst       (burst),
    .addr        (addr),
    .wdata       (wdata),
    .be          (be),
    .op_begun    (op_begun),
    .op_finished (op_finished),
    .ctrlr_good  (ctrlr_good)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  rgb;
    bit          issue;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_px(input logic [9:0] x, input logic [8:0] y, input logic [7:0] rgb);
    int n = 0;
    @(negedge clk);
    px_valid = 1'b1; px_x = x; px_y = y; px_rgb = rgb;
    while (!px_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!px_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_px timeout: px_ready stuck at 0 for pixel (%0d,%0d)", x, y);
    end
    @(negedge clk);
    px_valid = 1'b0;
  endtask

  // Called at a negedge; plays the controller for one write.
  task automatic serve_write(input string nm, input logic [22:0] ea,
                             input logic [15:0] ew, input logic [1:0] eb);
    int n = 0;
    while (!req_access && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_access) begin
      n_chk++; n_fail++;
      $display("FAIL %s.req timeout: req_access 0, expected 1", nm);
      return;
    end
    check({nm, ".addr"},  32'(addr),  32'(ea));
    check({nm, ".wdata"}, 32'(wdata), 32'(ew));
    check({nm, ".be"},    32'(be),    32'(eb));
    op_begun = 1'b1;
    @(negedge clk);
    op_begun = 1'b0;
    check({nm, ".req_drop"}, 32'(req_access), 32'd0);
    op_finished = 1'b1;
    @(negedge clk);
    op_finished = 1'b0;
  endtask

  task automatic expect_idle(input string nm, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (req_access) hits++;
    end
    check(nm, 32'(hits), 32'd0);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; px_valid = 1'b0; px_x = '0; px_y = '0; px_rgb = '0;
    op_begun = 1'b0; op_finished = 1'b0; ctrlr_good = 1'b1;

    //             x     y    rgb    issue addr       wdata      be
    vecs[0] = '{10'd3,   9'd2,   8'hA5, 1'b1, 23'd641,    16'hA5A5, 2'b10};
    vecs[1] = '{10'd0,   9'd0,   8'h11, 1'b1, 23'd0,      16'h1111, 2'b01};
    vecs[2] = '{10'd639, 9'd479, 8'hFF, 1'b1, 23'h0257FF, 16'hFFFF, 2'b10};
    vecs[3] = '{10'd640, 9'd0,   8'h5A, 1'b0, 23'd0,      16'h0000, 2'b00};
    vecs[4] = '{10'd0,   9'd480, 8'h5A, 1'b0, 23'd0,      16'h0000, 2'b00};
    vecs[5] = '{10'd5,   9'd1,   8'h7E, 1'b1, 23'd322,    16'h7E7E, 2'b10};
    vecs[6] = '{10'd2,   9'd0,   8'hC3, 1'b1, 23'd1,      16'hC3C3, 2'b01};
    vecs[7] = '{10'd1023,9'd511, 8'h00, 1'b0, 23'd0,      16'h0000, 2'b00};
    vecs[8] = '{10'd638, 9'd0,   8'h3C, 1'b1, 23'd319,    16'h3C3C, 2'b01};

    #1;
    check("rst.req_access", 32'(req_access), 32'd0);
    check("rst.px_ready",   32'(px_ready),   32'd1);
    check("rst.addr",       32'(addr),       32'd0);
    check("rst.wdata",      32'(wdata),      32'd0);
    check("rst.be",         32'(be),         32'd0);
    check("rst.rd",         32'(rd),         32'd0);
    check("rst.burst",      32'(burst),      32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a request.
    send_px(10'd100, 9'd0, 8'h77);
    @(negedge clk);
    check("midreq.req_before", 32'(req_access), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midreq.req_access", 32'(req_access), 32'd0);
    check("midreq.addr",       32'(addr),       32'd0);
    check("midreq.wdata",      32'(wdata),      32'd0);
    check("midreq.be",         32'(be),         32'd0);
    check("midreq.px_ready",   32'(px_ready),   32'd1);
    @(negedge clk);
    reset = 1'b1;

    // First write after reset, with 2-cycle accept-to-request latency.
    send_px(10'd3, 9'd2, 8'hA5);
    check("lat.cycle1", 32'(req_access), 32'd0);
    @(negedge clk);
    check("lat.cycle2", 32'(req_access), 32'd1);
    serve_write("post_rst", 23'd641, 16'hA5A5, 2'b10);
    expect_idle("post_rst.no_stale", 6);

    // Table of single pixels.
    for (int i = 0; i < 9; i++) begin
      send_px(vecs[i].x, vecs[i].y, vecs[i].rgb);
      if (vecs[i].issue)
        serve_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else
        expect_idle($sformatf("vec%0d.dropped", i), 8);
    end

    // Controller not good: requests held, then issued in order.
    ctrlr_good = 1'b0;
    send_px(10'd10, 9'd0, 8'h01);
    send_px(10'd20, 9'd0, 8'h02);
    expect_idle("cgood_low.hold", 10);
    ctrlr_good = 1'b1;
    serve_write("cgood.w0", 23'd5,  16'h0101, 2'b01);
    serve_write("cgood.w1", 23'd10, 16'h0202, 2'b01);
    expect_idle("cgood.done", 6);

    // Fill the FIFO while the controller never latches the first request.
    send_px(10'd0, 9'd3, 8'h40);
    send_px(10'd2, 9'd3, 8'h41);
    send_px(10'd4, 9'd3, 8'h42);
    send_px(10'd6, 9'd3, 8'h43);
    check("full.px_ready", 32'(px_ready), 32'd0);
    px_valid = 1'b1; px_x = 10'd8; px_y = 9'd3; px_rgb = 8'h44;
    begin
      int ready_hits = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (px_ready) ready_hits++;
      end
      check("full.held_off", 32'(ready_hits), 32'd0);
    end
    serve_write("full.w0", 23'd960, 16'h4040, 2'b01);
    check("full.ready_after_pop", 32'(px_ready), 32'd1);
    @(negedge clk);
    px_valid = 1'b0;
    serve_write("full.w1", 23'd961, 16'h4141, 2'b01);
    serve_write("full.w2", 23'd962, 16'h4242, 2'b01);
    serve_write("full.w3", 23'd963, 16'h4343, 2'b01);
    serve_write("full.w4", 23'd964, 16'h4444, 2'b01);
    expect_idle("full.done", 6);

    // Controller drops ctrlr_good while a request is pending.
    send_px(10'd7, 9'd0, 8'h99);
    @(negedge clk);
    check("abort.req_up", 32'(req_access), 32'd1);
    ctrlr_good = 1'b0;
    @(negedge clk);
    check("abort.req_drop", 32'(req_access), 32'd0);
    expect_idle("abort.hold", 3);
    ctrlr_good = 1'b1;
    serve_write("abort.reissue", 23'd3, 16'h9999, 2'b10);
    expect_idle("abort.done", 6);

    // Two pixels of one word queued before issue.
    ctrlr_good = 1'b0;
    send_px(10'd0, 9'd0, 8'h11);
    send_px(10'd1, 9'd0, 8'h22);
    ctrlr_good = 1'b1;
`ifdef FBW_MERGE_EN
    serve_write("merge.w", 23'd0, 16'h2211, 2'b11);
`else
    serve_write("nomerge.w0", 23'd0, 16'h1111, 2'b01);
    serve_write("nomerge.w1", 23'd0, 16'h2222, 2'b10);
`endif
    expect_idle("merge.done", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
